ofs_plat_host_chan_tlp_tx_arb: RTL

//  Parametrised N-channel arbiter merging AFU-side TX TLP streams (MMIO completions, read requests,

---
 rtl/ofs_plat_host_chan_tlp_tx_arb.sv | 110 +++++++++++
 1 files changed

// File: rtl/ofs_plat_host_chan_tlp_tx_arb.sv
// ofs_plat_host_chan_tlp_tx_arb: merges NUM_CH TX TLP streams onto one registered output with
// packet locking, optional strict ch0, per-owner packet quota round-robin and ch0 starvation limit.
module ofs_plat_host_chan_tlp_tx_arb #(
    parameter int NUM_CH       = 3,
    parameter int TDATA_WIDTH  = 512,
    parameter int TUSER_WIDTH  = 16,
    parameter bit STRICT_CH0   = 1'b1,
    parameter int QUOTA        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             in_tvalid,
    output logic [NUM_CH-1:0]             in_tready,
    input  logic [NUM_CH*TDATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_CH*TUSER_WIDTH-1:0] in_tuser,
    input  logic [NUM_CH-1:0]             in_tlast,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic [TDATA_WIDTH-1:0]        out_tdata,
    output logic [TUSER_WIDTH-1:0]        out_tuser,
    output logic                          out_tlast,
    output logic [$clog2(NUM_CH)-1:0]     out_ch
);
    localparam int CW = $clog2(NUM_CH);
    localparam logic [CW:0] N = (CW+1)'(NUM_CH);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_owner, r_rr_ptr, r_last_rr;
    logic [3:0]      r_quota;
    logic [7:0]      r_starve;
    logic [NUM_CH-1:0] w_pool;
    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_rr_win, w_win, w_sel, w_ptr_nxt;
    logic [3:0]      w_quota_inc, w_quota_new;
    logic            w_others, w_ch0_ok, w_keep, w_adv, w_go, w_acc, w_done, w_strict_pkt;

    assign w_others = |in_tvalid[NUM_CH-1:1];
    assign w_pool   = {in_tvalid[NUM_CH-1:1], in_tvalid[0] & ~STRICT_CH0};
    assign w_ch0_ok = STRICT_CH0 && in_tvalid[0] && !(r_starve == 8'(STARVE_LIMIT) && w_others);
    // a nonzero quota means the last RR owner still holds an unfinished turn
    assign w_keep   = r_quota != 4'd0 && r_quota < 4'(QUOTA) && in_tvalid[r_last_rr];

    // rotating scan from rr_ptr; descending k so the closest candidate is assigned last
    always_comb begin
        w_rr_win = '0;
        w_sum    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (CW+1)'(k);
            if (w_sum >= N) w_sum = w_sum - N;
            if (w_pool[w_sum[CW-1:0]]) w_rr_win = w_sum[CW-1:0];
        end
    end

    assign w_win        = w_ch0_ok ? '0 : w_keep ? r_last_rr : w_rr_win;
    assign w_sel        = r_state == LOCKED ? r_owner : w_win;
    assign w_adv        = !out_tvalid || out_tready;
    assign w_go         = w_adv && (r_state == LOCKED || |in_tvalid);
    assign in_tready    = (reset_n && w_go) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign w_acc        = w_adv && in_tvalid[w_sel];
    assign w_done       = w_acc && in_tlast[w_sel];
    assign w_strict_pkt = STRICT_CH0 && w_sel == '0;
    assign w_quota_inc  = r_quota == 4'(QUOTA) ? r_quota : r_quota + 4'd1;
    assign w_quota_new  = w_sel == r_last_rr ? w_quota_inc : 4'd1;
    assign w_ptr_nxt    = w_sel == CW'(NUM_CH - 1) ? CW'(STRICT_CH0) : w_sel + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) w_state_nxt = in_tlast[w_sel] ? IDLE : LOCKED;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= '0;
            r_rr_ptr   <= CW'(STRICT_CH0);
            r_last_rr  <= '0;
            r_quota    <= '0;
            r_starve   <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tuser  <= '0;
            out_tlast  <= 1'b0;
            out_ch     <= '0;
        end else begin
            if (w_acc) r_owner <= w_sel;
            if (w_done && w_strict_pkt) begin
                r_starve <= !w_others ? 8'd0 : r_starve == 8'hff ? r_starve : r_starve + 8'd1;
            end else if (w_done) begin
                r_starve  <= '0;
                r_last_rr <= w_sel;
                r_quota   <= w_quota_new == 4'(QUOTA) ? 4'd0 : w_quota_new;
                if (w_quota_new == 4'(QUOTA)) r_rr_ptr <= w_ptr_nxt;
            end
            if (w_adv) out_tvalid <= w_acc;
            if (w_acc) begin
                out_tdata <= in_tdata[w_sel*TDATA_WIDTH +: TDATA_WIDTH];
                out_tuser <= in_tuser[w_sel*TUSER_WIDTH +: TUSER_WIDTH];
                out_tlast <= in_tlast[w_sel];
                out_ch    <= w_sel;
            end
        end
    end
endmodule
